riscv_hwloop_regs: RTL and testbench
====================================

RISCV_HWLOOP_REGS -- requirements
Module: riscv_hwloop_regs

Interface
REQ-001 SHALL have parameter N_REGS, default 2, meaning number of hardware-loop register sets (1..4).
REQ-002 SHALL have parameter REGID_W, default 1, meaning width of the loop-select field; the value SHALL equal max(1, ceil(log2(N_REGS))).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 hwlp_start_data_i  input  32  start address write data.
REQ-006 hwlp_end_data_i  input  32  end address write data.
REQ-007 hwlp_cnt_data_i  input  32  loop count write data.
REQ-008 hwlp_we_i  input  3  write enables: bit0 start, bit1 end, bit2 counter.
REQ-009 hwlp_regid_i  input  REGID_W  loop set targeted by hwlp_we_i.
REQ-010 hwlp_dec_cnt_i  input  N_REGS  per-set counter decrement request from the loop controller.
REQ-011 hwlp_start_addr_o  output  N_REGS*32  start addresses, set k in bits [32k+31:32k].
REQ-012 hwlp_end_addr_o  output  N_REGS*32  end addresses, same packing.
REQ-013 hwlp_counter_o  output  N_REGS*32  loop counters, same packing.
REQ-014 hwlp_active_o  output  N_REGS  bit k high iff counter k is non-zero.

Function
REQ-015 Each set SHALL hold three 32-bit registers (start, end, counter); outputs SHALL be driven directly from registers, with no combinational path from any input to any output.
REQ-016 On a rising edge with hwlp_we_i[n] high and hwlp_regid_i < N_REGS, the selected register of set hwlp_regid_i SHALL load its data input; the new value SHALL be visible on the outputs in the following cycle (1-cycle latency).
REQ-017 Any combination of the three enables SHALL be accepted in one cycle; each enabled field SHALL update independently.
REQ-018 A write with hwlp_regid_i >= N_REGS SHALL be ignored; no register SHALL change.
REQ-019 hwlp_dec_cnt_i[k] high SHALL decrement counter k by exactly 1 at the next edge, using modulo-2^32 arithmetic unless REQ-026 applies.
REQ-020 A counter write and a decrement to the same set in the same cycle SHALL load the written value; the decrement SHALL be dropped.
REQ-021 A counter write to one set and decrements to other sets in the same cycle SHALL all take effect.
REQ-022 Decrements to multiple sets in the same cycle SHALL all take effect.
REQ-023 Start and end registers SHALL never be modified by hwlp_dec_cnt_i.
REQ-024 hwlp_active_o[k] SHALL be registered-consistent: it SHALL equal (counter k != 0) in the same cycle as hwlp_counter_o.

Reset
REQ-025 While rst is high at a rising edge, every start, end, and counter register SHALL become 32'h0 and hwlp_active_o SHALL become all zero; reset SHALL override any simultaneous write or decrement, including an operation already in progress.

Configuration
REQ-026 Macro HWLP_UNDERFLOW_GUARD_EN: when defined, a decrement of a counter that equals 0 SHALL be ignored, and the counter SHALL stay 0; when undefined, that counter SHALL wrap to 32'hFFFF_FFFF.

Verification
REQ-027 Reset then write set 0 start=0x100, end=0x120, cnt=3 (we=3'b111, regid=0) -> next cycle outputs set0 = 0x100/0x120/3, active=2'b01, set1 all 0.
REQ-028 With cnt0=3, pulse dec[0] for three cycles -> counter reads 2, 1, 0; active[0] falls in the cycle the counter reads 0.
REQ-029 With cnt0=5, write cnt=10 to set 0 and assert dec=2'b11 in the same cycle, with cnt1=4 -> set0 counter=10, set1 counter=3.
REQ-030 With cnt0=0, assert dec[0] -> counter=0 with HWLP_UNDERFLOW_GUARD_EN defined; counter=0xFFFF_FFFF and active[0]=1 without it.
REQ-031 With N_REGS=3, REGID_W=2, write regid=3 with we=3'b111 -> no register changes.
REQ-032 Assert rst together with a write and a decrement -> all outputs read 0 in the next cycle.

Source files
------------

// File: rtl/riscv_hwloop_regs.sv
// Hardware-loop register file: per-set start/end/counter registers with counter decrement.
// Optional macro HWLP_UNDERFLOW_GUARD_EN: a decrement of a zero counter holds it at zero instead of wrapping.
module riscv_hwloop_regs #(
  parameter int N_REGS  = 2,
  parameter int REGID_W = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            hwlp_start_data_i,
  input  logic [31:0]            hwlp_end_data_i,
  input  logic [31:0]            hwlp_cnt_data_i,
  input  logic [2:0]             hwlp_we_i,
  input  logic [REGID_W-1:0]     hwlp_regid_i,
  input  logic [N_REGS-1:0]      hwlp_dec_cnt_i,
  output logic [N_REGS*32-1:0]   hwlp_start_addr_o,
  output logic [N_REGS*32-1:0]   hwlp_end_addr_o,
  output logic [N_REGS*32-1:0]   hwlp_counter_o,
  output logic [N_REGS-1:0]      hwlp_active_o
);

  logic [31:0]       r_start [N_REGS];
  logic [31:0]       r_end   [N_REGS];
  logic [31:0]       r_cnt   [N_REGS];
  logic [N_REGS-1:0] r_active;

  logic [N_REGS-1:0] w_sel;
  logic [31:0]       w_cnt_nxt [N_REGS];
  logic              w_regid_ok;

  function automatic logic [31:0] f_dec_cnt(input logic [31:0] cnt);
`ifdef HWLP_UNDERFLOW_GUARD_EN
    f_dec_cnt = (cnt == 32'h0) ? 32'h0 : cnt - 32'd1;
`else
    f_dec_cnt = cnt - 32'd1;
`endif
  endfunction

  assign w_regid_ok = (32'(hwlp_regid_i) < 32'(N_REGS));

  // A counter write to a set wins over a same-cycle decrement of that set.
  always_comb begin
    w_sel = '0;
    for (int k = 0; k < N_REGS; k++) begin
      w_sel[k] = w_regid_ok && (32'(hwlp_regid_i) == 32'(k));
      if (w_sel[k] && hwlp_we_i[2]) begin
        w_cnt_nxt[k] = hwlp_cnt_data_i;
      end else if (hwlp_dec_cnt_i[k]) begin
        w_cnt_nxt[k] = f_dec_cnt(r_cnt[k]);
      end else begin
        w_cnt_nxt[k] = r_cnt[k];
      end
    end
  end

  // Active flag is registered from the next counter value so it tracks the counter exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N_REGS; k++) begin
        r_start[k] <= '0;
        r_end[k]   <= '0;
        r_cnt[k]   <= '0;
      end
      r_active <= '0;
    end else begin
      for (int k = 0; k < N_REGS; k++) begin
        if (w_sel[k] && hwlp_we_i[0]) r_start[k] <= hwlp_start_data_i;
        if (w_sel[k] && hwlp_we_i[1]) r_end[k]   <= hwlp_end_data_i;
        r_cnt[k]    <= w_cnt_nxt[k];
        r_active[k] <= |w_cnt_nxt[k];
      end
    end
  end

  for (genvar g = 0; g < N_REGS; g++) begin : g_pack
    assign hwlp_start_addr_o[32*g +: 32] = r_start[g];
    assign hwlp_end_addr_o[32*g +: 32]   = r_end[g];
    assign hwlp_counter_o[32*g +: 32]    = r_cnt[g];
  end

  assign hwlp_active_o = r_active;

endmodule

// File: tb/tb_riscv_hwloop_regs.sv
// Scoreboard bench for riscv_hwloop_regs (three loop sets, two-bit loop select).
module tb_riscv_hwloop_regs;

  localparam int N = 3;
  localparam int RW = 2;

  logic              clk;
  logic              rst;
  logic [31:0]       start_d, end_d, cnt_d;
  logic [2:0]        we;
  logic [RW-1:0]     regid;
  logic [N-1:0]      dec;
  logic [N*32-1:0]   start_o, end_o, cnt_o;
  logic [N-1:0]      act_o;

  riscv_hwloop_regs #(.N_REGS(N), .REGID_W(RW)) u_dut (
    .clk               (clk),
    .rst               (rst),
    .hwlp_start_data_i (start_d),
    .hwlp_end_data_i   (end_d),
    .hwlp_cnt_data_i   (cnt_d),
    .hwlp_we_i         (we),
    .hwlp_regid_i      (regid),
    .hwlp_dec_cnt_i    (dec),
    .hwlp_start_addr_o (start_o),
    .hwlp_end_addr_o   (end_o),
    .hwlp_counter_o    (cnt_o),
    .hwlp_active_o     (act_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [N*32-1:0] st;
    logic [N*32-1:0] en;
    logic [N*32-1:0] cnt;
    logic [N-1:0]    act;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;

  logic [31:0] e_st [N];
  logic [31:0] e_en [N];
  logic [31:0] e_cnt[N];
  logic [N-1:0] e_act;
`ifdef HWLP_UNDERFLOW_GUARD_EN
  localparam logic [31:0] UNDER = 32'h0000_0000;
`else
  localparam logic [31:0] UNDER = 32'hFFFF_FFFF;
`endif

  // Drive one cycle of inputs on the falling edge and queue the expected post-edge state.
  task automatic step(input logic r, input logic [2:0] w, input logic [RW-1:0] id,
                      input logic [31:0] s, input logic [31:0] e, input logic [31:0] c,
                      input logic [N-1:0] d, input string nm);
    exp_t x;
    @(negedge clk);
    rst = r; we = w; regid = id; start_d = s; end_d = e; cnt_d = c; dec = d;
    for (int k = 0; k < N; k++) begin
      x.st[32*k +: 32]  = e_st[k];
      x.en[32*k +: 32]  = e_en[k];
      x.cnt[32*k +: 32] = e_cnt[k];
    end
    x.act = e_act;
    exp_q.push_back(x);
    name_q.push_back(nm);
  endtask

  task automatic set_exp(input int k, input logic [31:0] s, input logic [31:0] e,
                         input logic [31:0] c, input logic a);
    e_st[k] = s; e_en[k] = e; e_cnt[k] = c; e_act[k] = a;
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t  x;
      string nm;
      x  = exp_q.pop_front();
      nm = name_q.pop_front();
      checks++;
      if (start_o !== x.st) begin
        errors++; $display("FAIL %s start: got %h expected %h", nm, start_o, x.st);
      end
      checks++;
      if (end_o !== x.en) begin
        errors++; $display("FAIL %s end: got %h expected %h", nm, end_o, x.en);
      end
      checks++;
      if (cnt_o !== x.cnt) begin
        errors++; $display("FAIL %s counter: got %h expected %h", nm, cnt_o, x.cnt);
      end
      checks++;
      if (act_o !== x.act) begin
        errors++; $display("FAIL %s active: got %b expected %b", nm, act_o, x.act);
      end
    end
  end

  initial begin
    int budget;
    rst = 1'b1; we = '0; regid = '0; start_d = '0; end_d = '0; cnt_d = '0; dec = '0;
    for (int k = 0; k < N; k++) set_exp(k, 32'h0, 32'h0, 32'h0, 1'b0);

    step(1'b1, 3'b000, 2'd0, 32'h0, 32'h0, 32'h0, 3'b000, "reset");
    step(1'b1, 3'b111, 2'd0, 32'h111, 32'h222, 32'h9, 3'b111, "reset_busy");

    set_exp(0, 32'h100, 32'h120, 32'd3, 1'b1);
    step(1'b0, 3'b111, 2'd0, 32'h100, 32'h120, 32'd3, 3'b000, "wr_set0");
    set_exp(0, 32'h100, 32'h120, 32'd2, 1'b1);
    step(1'b0, 3'b000, 2'd0, 32'h0, 32'h0, 32'h0, 3'b001, "dec_to2");
    set_exp(0, 32'h100, 32'h120, 32'd1, 1'b1);
    step(1'b0, 3'b000, 2'd0, 32'h0, 32'h0, 32'h0, 3'b001, "dec_to1");
    set_exp(0, 32'h100, 32'h120, 32'd0, 1'b0);
    step(1'b0, 3'b000, 2'd0, 32'h0, 32'h0, 32'h0, 3'b001, "dec_to0");
    set_exp(0, 32'h100, 32'h120, UNDER, UNDER != 32'h0);
    step(1'b0, 3'b000, 2'd0, 32'h0, 32'h0, 32'h0, 3'b001, "underflow");

    set_exp(0, 32'h100, 32'h120, 32'd5, 1'b1);
    step(1'b0, 3'b100, 2'd0, 32'hAAAA, 32'hBBBB, 32'd5, 3'b000, "wr_cnt_only");
    set_exp(1, 32'h200, 32'h240, 32'd4, 1'b1);
    step(1'b0, 3'b111, 2'd1, 32'h200, 32'h240, 32'd4, 3'b000, "wr_set1");
    set_exp(0, 32'h100, 32'h120, 32'd10, 1'b1);
    set_exp(1, 32'h200, 32'h240, 32'd3, 1'b1);
    step(1'b0, 3'b100, 2'd0, 32'h0, 32'h0, 32'd10, 3'b011, "wr_dec_same_cycle");
    set_exp(0, 32'h100, 32'h120, 32'd9, 1'b1);
    set_exp(1, 32'h200, 32'h240, 32'd2, 1'b1);
    set_exp(2, 32'h0, 32'h0, UNDER, UNDER != 32'h0);
    step(1'b0, 3'b000, 2'd0, 32'h0, 32'h0, 32'h0, 3'b111, "multi_dec");

    step(1'b0, 3'b111, 2'd3, 32'hDEAD, 32'hBEEF, 32'hCAFE, 3'b000, "regid_oob");
    set_exp(2, 32'h0, 32'h300, UNDER, UNDER != 32'h0);
    step(1'b0, 3'b010, 2'd2, 32'h777, 32'h300, 32'h888, 3'b000, "wr_end_only");
    set_exp(2, 32'h280, 32'h300, 32'd7, 1'b1);
    step(1'b0, 3'b101, 2'd2, 32'h280, 32'h999, 32'd7, 3'b000, "wr_start_cnt");
    set_exp(2, 32'h280, 32'h300, 32'd6, 1'b1);
    step(1'b0, 3'b000, 2'd0, 32'h0, 32'h0, 32'h0, 3'b100, "dec_set2");
    step(1'b0, 3'b000, 2'd0, 32'h0, 32'h0, 32'h0, 3'b000, "hold");

    for (int k = 0; k < N; k++) set_exp(k, 32'h0, 32'h0, 32'h0, 1'b0);
    step(1'b1, 3'b111, 2'd1, 32'h555, 32'h666, 32'd8, 3'b111, "rst_override");
    step(1'b0, 3'b000, 2'd0, 32'h0, 32'h0, 32'h0, 3'b000, "after_rst");

    budget = 0;
    while (exp_q.size() > 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    #2;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
